fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, PC and address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 64'h8000_0000, PC loaded on reset.
REQ-004 SHALL have parameter BUF_DEPTH, default 4, instruction buffer entries; power of two, >=2.
REQ-005 SHALL have port: clk  in  1  single clock, rising edge.
REQ-006 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port: redirect_valid  in  1  branch/jump redirect strobe.
REQ-008 SHALL have port: redirect_pc  in  ADDR_W  redirect target.
REQ-009 SHALL have port: imem_req_valid  out  1  fetch request valid.
REQ-010 SHALL have port: imem_req_ready  in  1  memory accepts request.
REQ-011 SHALL have port: imem_req_addr  out  ADDR_W  fetch address.
REQ-012 SHALL have port: imem_rsp_valid  in  1  instruction data returned.
REQ-013 SHALL have port: imem_rsp_data  in  INST_W  returned instruction.
REQ-014 SHALL have port: inst_valid  out  1  buffered instruction available to decode.
REQ-015 SHALL have port: inst_ready  in  1  decode accepts instruction.
REQ-016 SHALL have port: inst_data  out  INST_W  head instruction.
REQ-017 SHALL have port: inst_pc  out  ADDR_W  PC of head instruction.

Function
REQ-018 SHALL allow at most one outstanding memory request; states FETCH, WAIT, FLUSH.
REQ-019 FETCH: imem_req_valid=1 iff buffer count<BUF_DEPTH; imem_req_addr=pc; on valid&ready: req_pc<=pc, pc<=pc+4 (mod 2^ADDR_W), go WAIT.
REQ-020 WAIT: imem_req_valid=0; on imem_rsp_valid push {req_pc, imem_rsp_data} into buffer, go FETCH.
REQ-021 FLUSH: imem_req_valid=0; on imem_rsp_valid discard data, go FETCH.
REQ-022 imem_rsp_valid in FETCH SHALL be ignored.
REQ-023 redirect_valid SHALL have priority over all other events: pc<=redirect_pc with bits[1:0] forced to 0, buffer emptied (count=0, pointers reset).
REQ-024 Redirect in WAIT without rsp, or in FETCH coinciding with request handshake, SHALL go FLUSH; redirect in WAIT/FLUSH with rsp in same cycle SHALL drop rsp and go FETCH; redirect in FLUSH without rsp stays FLUSH.
REQ-025 inst_valid SHALL equal (count!=0); inst_data/inst_pc SHALL come from registered head entry; pop on inst_valid&inst_ready.
REQ-026 Simultaneous push and pop SHALL leave count unchanged; overflow SHALL be impossible by REQ-019 gating.
REQ-027 Latency: response in cycle N SHALL give inst_valid in cycle N+1 (empty buffer); peak throughput one instruction per two cycles.
REQ-028 Decode handshake in a redirect cycle SHALL count as consumed; buffer is still emptied.

Reset
REQ-029 While rst=1: state=FETCH, pc=RESET_PC, count=0, pointers=0, imem_req_valid=0, inst_valid=0.
REQ-030 First cycle after rst deasserts SHALL present imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-031 Reset asserted mid-WAIT SHALL abandon the outstanding response; memory side is reset concurrently.

Structure
REQ-032 Shared package fetch_pkg SHALL hold the state enum, INST_BYTES=4, and default RESET_PC.
REQ-033 Buffer SHALL be sub-module fetch_buf (synchronous FIFO, width ADDR_W+INST_W, depth BUF_DEPTH, with flush input).

Verification
REQ-034 Reset release, ready=1, rsp one cycle after request -> addrs 0x80000000, 0x80000004, 0x80000008 with matching inst_pc order.
REQ-035 inst_ready=0, 6 fetches offered -> exactly 4 requests, then imem_req_valid=0 until one pop.
REQ-036 Redirect to 0x80001002 during WAIT -> response dropped, next request addr 0x80001000, inst_valid=0 until new rsp.
REQ-037 Redirect same cycle as rsp in WAIT -> rsp dropped, request to target next cycle, no FLUSH.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next addr 0x0.
REQ-039 rst pulsed mid-WAIT with 2 buffered -> inst_valid=0, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding, instruction size and default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam int INST_BYTES = 4;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched {pc, instruction} entries for decode.
// Ports: clk, rst (async high), flush (empties buffer), push/push_data,
// pop, head_data (registered head entry), count (entries held).
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int W     = 96,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            // Flush wins over any same-cycle push/pop.
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, FIFO to decode.
// Ports: clk, rst, redirect_valid/pc, imem_req_*, imem_rsp_*, inst_*.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                INST_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int EW = ADDR_W + INST_W;

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic [CW-1:0]     buf_count;
    logic [EW-1:0]     head;
    logic              req_fire;
    logic              push;
    logic              pop;

    // rst gates the request so it reads low even before the state settles.
    assign imem_req_valid = !rst && (state == ST_FETCH)
                         && (buf_count < CW'(BUF_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A redirect in the response cycle drops the response.
    assign push = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop  = inst_valid & inst_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_FETCH: begin
                if (req_fire) begin
                    state_nxt = redirect_valid ? ST_FLUSH : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem_rsp_valid ? ST_FETCH : ST_FLUSH;
                end else if (imem_rsp_valid) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (imem_rsp_valid) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                req_pc <= pc;
            end
            if (redirect_valid) begin
                pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (req_fire) begin
                pc <= pc + ADDR_W'(INST_BYTES);
            end
        end
    end

    fetch_buf #(
        .W     (EW),
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data ({req_pc, imem_rsp_data}),
        .pop       (pop),
        .head_data (head),
        .count     (buf_count)
    );

    assign inst_valid = (buf_count != '0);
    assign inst_pc    = head[EW-1:INST_W];
    assign inst_data  = head[INST_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Hand-written vectors cover reset, throughput, backpressure and redirects.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request/response round trip; rsp arrives the cycle after accept.
    task automatic fetch_one(input logic [63:0] addr, input logic [31:0] d);
        chk("req_valid", 64'(imem_req_valid), 64'd1);
        chk("req_addr", imem_req_addr, addr);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_no_req", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        step();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic pop_one(input logic [63:0] pc, input logic [31:0] d);
        chk("pop_valid", 64'(inst_valid), 64'd1);
        chk("pop_pc", inst_pc, pc);
        chk("pop_data", 64'(inst_data), 64'(d));
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rel_req_addr", imem_req_addr, 64'h8000_0000);

        // Sequential fetch, in-order delivery
        fetch_one(64'h8000_0000, 32'h0000_0011);
        chk("lat_inst_valid", 64'(inst_valid), 64'd1);
        fetch_one(64'h8000_0004, 32'h0000_0022);
        fetch_one(64'h8000_0008, 32'h0000_0033);
        pop_one(64'h8000_0000, 32'h0000_0011);
        pop_one(64'h8000_0004, 32'h0000_0022);
        pop_one(64'h8000_0008, 32'h0000_0033);
        chk("drained", 64'(inst_valid), 64'd0);

        // Backpressure: buffer fills at 4, requests stop
        fetch_one(64'h8000_000C, 32'h0000_0044);
        fetch_one(64'h8000_0010, 32'h0000_0055);
        fetch_one(64'h8000_0014, 32'h0000_0066);
        fetch_one(64'h8000_0018, 32'h0000_0077);
        chk("full_no_req", 64'(imem_req_valid), 64'd0);
        imem_req_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        chk("full_still_no_req", 64'(imem_req_valid), 64'd0);
        pop_one(64'h8000_000C, 32'h0000_0044);
        chk("after_pop_req", 64'(imem_req_valid), 64'd1);
        chk("after_pop_addr", imem_req_addr, 64'h8000_001C);

        // Redirect during WAIT without rsp -> FLUSH
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1002;
        step();
        redirect_valid = 1'b0;
        chk("flush_inst_valid", 64'(inst_valid), 64'd0);
        chk("flush_no_req", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("dropped_rsp", 64'(inst_valid), 64'd0);
        fetch_one(64'h8000_1000, 32'h0000_0088);
        pop_one(64'h8000_1000, 32'h0000_0088);

        // Redirect with rsp in WAIT -> straight to FETCH
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0099;
        step();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("rr_inst_valid", 64'(inst_valid), 64'd0);
        chk("rr_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rr_req_addr", imem_req_addr, 64'h8000_2000);

        // Redirect coinciding with request handshake -> FLUSH
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_3000;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("hs_flush_no_req", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        step();
        imem_rsp_valid = 1'b0;
        chk("hs_inst_valid", 64'(inst_valid), 64'd0);
        chk("hs_req_addr", imem_req_addr, 64'h8000_3000);

        // PC wraparound
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_00AA);
        chk("wrap_addr", imem_req_addr, 64'h0);
        pop_one(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_00AA);

        // Reset mid-WAIT with two buffered
        fetch_one(64'h0, 32'h0000_00BB);
        fetch_one(64'h4, 32'h0000_00CC);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("pre_rst_valid", 64'(inst_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("mid_rst_req_valid", 64'(imem_req_valid), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("restart_req_valid", 64'(imem_req_valid), 64'd1);
        chk("restart_addr", imem_req_addr, 64'h8000_0000);
        chk("restart_inst_valid", 64'(inst_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
